// File: rtl/cache_line_tracker_mc.sv
// rtl/cache_line_tracker_mc.sv - samples expired-line vectors every period_i accepted requests into a host-readable buffer
// Optional macro TRACKER_TIMESTAMP_EN adds a free-running cycle count to every entry (rd_timestamp_o).
module cache_line_tracker_mc #(
  parameter int N_LINES    = 128,
  parameter int N_CHANNELS = 3,
  parameter int DEPTH      = 4096,
  parameter int BW_TRACE   = 64
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          enable_i,
  input  logic                          clear_i,
  input  logic                          wrap_i,
  input  logic [31:0]                   period_i,
  input  logic                          request_i,
  input  logic                          en_i,
  input  logic [N_CHANNELS*N_LINES-1:0] expired_bits_i,
  input  logic                          rd_req_i,
  input  logic [$clog2(DEPTH)-1:0]      rd_addr_i,
  output logic                          stall_o,
  output logic [$clog2(DEPTH):0]        count_o,
  output logic                          overflow_o,
  output logic                          rd_valid_o,
  output logic [N_CHANNELS*N_LINES-1:0] rd_bits_o,
`ifdef TRACKER_TIMESTAMP_EN
  output logic [31:0]                   rd_timestamp_o,
`endif
  output logic [BW_TRACE-1:0]           rd_trace_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = N_CHANNELS * N_LINES;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {IDLE, TRACK, FULL} state_t;

  state_t              state_q, state_d;
  logic                stall_q, stall_d;
  logic [AW:0]         count_q, count_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic                overflow_q, overflow_d;
  logic                rd_valid_q, rd_valid_d;
  logic [BW_TRACE-1:0] trace_q, trace_d;
  logic [31:0]         samp_q, samp_d;

  logic                accept;
  logic                sample;
  logic                wr_en;
  logic                rd_fire;
  logic [31:0]         period_eff;

  logic [BW-1:0]       bits_mem_q  [DEPTH];
  logic [BW_TRACE-1:0] trace_mem_q [DEPTH];
  logic [BW-1:0]       rd_bits_q;
  logic [BW_TRACE-1:0] rd_trace_q;

`ifdef TRACKER_TIMESTAMP_EN
  logic [31:0]         ts_q, ts_d;
  logic [31:0]         ts_mem_q [DEPTH];
  logic [31:0]         rd_ts_q;
`endif

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q;
    samp_d     = samp_q;

    period_eff = (period_i == 32'd0) ? 32'd1 : period_i;
    accept     = (state_q == TRACK) && en_i && request_i;
    trace_d    = trace_q + {{(BW_TRACE-1){1'b0}}, accept};
    sample     = accept && (samp_q == 32'd1);
    // clear_i wins over a coincident sample; the request itself still counts
    wr_en      = sample && !clear_i;
    rd_fire    = rd_req_i && ((state_q == IDLE) || (state_q == FULL));
    rd_valid_d = rd_fire;

    if (accept) begin
      samp_d = sample ? period_eff : samp_q - 32'd1;
    end

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (count_q == FULL_CNT) begin
        if (wrap_i) begin
          overflow_d = 1'b1;
        end
      end else begin
        count_d = count_q + CNT_ONE;
      end
    end

    if (clear_i) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      overflow_d = 1'b0;
      samp_d     = period_eff;
    end

    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d = TRACK;
          samp_d  = period_eff;
        end
      end
      TRACK: begin
        if (!enable_i) begin
          state_d = IDLE;
        end else if (wr_en && !wrap_i && (count_d == FULL_CNT)) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (!enable_i) begin
          state_d = IDLE;
        end else if (clear_i) begin
          state_d = TRACK;
        end
      end
      default: state_d = IDLE;
    endcase

    stall_d = (state_d == FULL);
  end

`ifdef TRACKER_TIMESTAMP_EN
  always_comb begin
    ts_d = ts_q + 32'd1;
  end
`endif

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      stall_q    <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      trace_q    <= '0;
      samp_q     <= 32'd1;
`ifdef TRACKER_TIMESTAMP_EN
      ts_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      stall_q    <= stall_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      overflow_q <= overflow_d;
      rd_valid_q <= rd_valid_d;
      trace_q    <= trace_d;
      samp_q     <= samp_d;
`ifdef TRACKER_TIMESTAMP_EN
      ts_q       <= ts_d;
`endif
    end
  end

  // Storage has no reset; only entries below count_o carry meaning.
  always_ff @(posedge clock_i) begin
    if (wr_en) begin
      bits_mem_q[wr_ptr_q]  <= expired_bits_i;
      trace_mem_q[wr_ptr_q] <= trace_d;
`ifdef TRACKER_TIMESTAMP_EN
      ts_mem_q[wr_ptr_q]    <= ts_q;
`endif
    end
    if (rd_fire) begin
      rd_bits_q  <= bits_mem_q[rd_addr_i];
      rd_trace_q <= trace_mem_q[rd_addr_i];
`ifdef TRACKER_TIMESTAMP_EN
      rd_ts_q    <= ts_mem_q[rd_addr_i];
`endif
    end
  end

  assign stall_o    = stall_q;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_bits_o  = rd_bits_q;
  assign rd_trace_o = rd_trace_q;
`ifdef TRACKER_TIMESTAMP_EN
  assign rd_timestamp_o = rd_ts_q;
`endif

endmodule

// File: doc/cache_line_tracker_mc.md
CACHE_LINE_TRACKER_MC -- requirements
Module: cache_line_tracker_mc

Interface
REQ-001 Parameter N_LINES, default 128: number of cache lines covered by one expired-bit vector.
REQ-002 Parameter N_CHANNELS, default 3, range 1-8: number of expired-bit vectors captured per sample.
REQ-003 Parameter DEPTH, default 4096, power of two, at least 2: buffer entries.
REQ-004 Parameter BW_TRACE, default 64: width of the request trace counter.
REQ-005 Ports, listed as name, direction, width, meaning:
- clock_i, in, 1: the single clock.
- reset_i, in, 1: asynchronous, active-high reset.
- enable_i, in, 1: tracking enable.
- clear_i, in, 1: buffer clear pulse.
- wrap_i, in, 1: 1 selects ring mode, 0 selects stall mode.
- period_i, in, 32: sampling period, counted in requests.
- request_i, in, 1: one cache request this cycle.
- en_i, in, 1: sampler selected; when 0, requests are ignored.
- expired_bits_i, in, N_CHANNELS*N_LINES: channel c occupies bits [c*N_LINES +: N_LINES].
- rd_req_i, in, 1: host read strobe.
- rd_addr_i, in, clog2(DEPTH): host read address.
- stall_o, out, 1: stall request to the cache controller.
- count_o, out, clog2(DEPTH)+1: number of valid entries.
- overflow_o, out, 1: sticky flag, set when a ring-mode write overwrites an entry.
- rd_valid_o, out, 1: read data valid.
- rd_bits_o, out, N_CHANNELS*N_LINES: stored expired bits.
- rd_trace_o, out, BW_TRACE: stored trace count.

Function
REQ-006 FSM has three states, IDLE, TRACK and FULL; stall_o is 1 only in FULL.
REQ-007 IDLE -> TRACK when enable_i=1; TRACK or FULL -> IDLE when enable_i=0; TRACK -> FULL on the write that makes count reach DEPTH, stall mode only; FULL -> TRACK on clear_i with enable_i=1.
REQ-008 A request is accepted when the state is TRACK, en_i=1 and request_i=1; at most one request is accepted per cycle.
REQ-009 Each accepted request increments the trace counter, which wraps modulo 2^BW_TRACE and is never cleared except by reset.
REQ-010 Each accepted request decrements the sample counter; an accepted request arriving with sample counter==1 is a sample event, and the sample counter reloads with period_i.
REQ-011 period_i=0 is treated as 1, so every accepted request samples.
REQ-012 The sample counter loads period_i on the IDLE->TRACK transition and on clear_i.
REQ-013 A sample event writes {expired_bits_i, trace counter value including this request} to the entry at wr_ptr in the same clock edge, then increments wr_ptr modulo DEPTH.
REQ-014 Stall mode: count increments per write, and the write that brings count to DEPTH moves the FSM to FULL on the same edge, so stall_o is 1 from the next cycle.
REQ-015 No write occurs in FULL.
REQ-016 Ring mode: count saturates at DEPTH, and a write made with count==DEPTH overwrites the oldest entry and sets overflow_o.
REQ-017 Ring mode never enters FULL.
REQ-018 Host reads are served only in IDLE or FULL: rd_req_i at edge N produces rd_valid_o=1 with the entry at rd_addr_i during cycle N+1.
REQ-019 rd_req_i in TRACK is ignored and rd_valid_o stays 0.
REQ-020 clear_i zeroes count, wr_ptr and overflow_o, and has priority over a sample event in the same cycle; that sample is dropped.
REQ-021 The trace counter still counts the request dropped under REQ-020.
REQ-022 Changing wrap_i takes effect on the next write only; it is not retroactive on count or state.
REQ-023 Buffer contents are undefined after reset; only entries below count are meaningful.

Reset
REQ-024 reset_i asserted resets immediately, with no clock required: state=IDLE, stall_o=0, count_o=0, overflow_o=0, rd_valid_o=0, wr_ptr=0, trace counter=0, sample counter=1.
REQ-025 Reset asserted while in FULL deasserts stall_o combinationally.
REQ-026 Reset is released synchronously to clock_i by the surrounding logic.

Configuration
REQ-027 Macro TRACKER_TIMESTAMP_EN.
REQ-028 When TRACKER_TIMESTAMP_EN is defined: a free-running 32-bit cycle counter, reset to 0, is stored with each entry and returned on output port rd_timestamp_o, 32 bits, with the same timing as rd_trace_o.
REQ-029 When TRACKER_TIMESTAMP_EN is undefined: the cycle counter, its storage and the rd_timestamp_o port do not exist, and all other behaviour is identical.

Verification
REQ-030 DEPTH=4, period_i=2, stall mode, 8 accepted requests -> 4 writes with trace 2, 4, 6, 8; stall_o=1 starting the cycle after the 8th request; count_o=4.
REQ-031 From the REQ-030 end state, rd_req_i with rd_addr_i=2 -> rd_valid_o=1 one cycle later with rd_trace_o=6; then clear_i -> stall_o=0, count_o=0.
REQ-032 DEPTH=4, ring mode, period_i=1, 6 requests -> count_o=4, overflow_o=1, entry 0 trace=5, entry 1 trace=6.
REQ-033 clear_i coincident with a sample event -> no write, count_o=0, trace counter still incremented.
REQ-034 en_i=0 or rd_req_i during TRACK -> trace counter unchanged and rd_valid_o=0; period_i=0 -> every accepted request writes an entry.
REQ-035 reset_i pulse mid-cycle while in FULL -> stall_o=0 before the next clock edge; all outputs at their reset values.
